// File: rtl/gumnut_pkg.sv
// Shared definitions for the Gumnut control sequencer.
// Holds the state codes, the memory/port function codes and a width helper.
package gumnut_pkg;

  localparam logic [2:0] FETCH   = 3'd0;
  localparam logic [2:0] DECODE  = 3'd1;
  localparam logic [2:0] EXECUTE = 3'd2;
  localparam logic [2:0] MEM     = 3'd3;
  localparam logic [2:0] WB      = 3'd4;
  localparam logic [2:0] INT     = 3'd5;
  localparam logic [2:0] ERR     = 3'd6;

  localparam logic [1:0] MEM_FN_LDM = 2'b00;
  localparam logic [1:0] MEM_FN_STM = 2'b01;
  localparam logic [1:0] MEM_FN_INP = 2'b10;
  localparam logic [1:0] MEM_FN_OUT = 2'b11;

  // Number of bits needed to hold values 0..value-1.
  function automatic int gumnut_clog2(input int value);
    int width;
    width = 0;
    while ((1 << width) < value) width++;
    return width;
  endfunction

endpackage

// File: rtl/gumnut_int_arb.sv
// Fixed-priority interrupt arbiter: channel 0 wins.
// Grant and index are captured on the load strobe and held afterwards.
module gumnut_int_arb #(
  parameter int CHANNELS = 4
) (
  input  logic                clk,
  input  logic                srst,
  input  logic                load,
  input  logic                en,
  input  logic [CHANNELS-1:0] req,
  output logic [CHANNELS-1:0] grant,
  output logic [2:0]          index
);

  logic [CHANNELS-1:0] masked;
  logic [2:0]          pick;
  logic [CHANNELS-1:0] grant_reg;
  logic [2:0]          index_reg;

  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_mask
      assign masked[gi] = en & req[gi];
    end
  endgenerate

  // Scan from the top so the lowest asserted channel is left in pick;
  // with nothing asserted channel 0 is chosen.
  always_comb begin
    pick = 3'd0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (masked[i]) pick = 3'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      grant_reg <= '0;
      index_reg <= 3'd0;
    end else if (load) begin
      grant_reg <= CHANNELS'(1) << pick;
      index_reg <= pick;
    end
  end

  assign grant = grant_reg;
  assign index = index_reg;

endmodule

// File: rtl/gumnut_ctrl_seq.sv
// Gumnut control sequencer: fetch/decode/execute/mem/write-back FSM with
// prioritised interrupts and a bus-ack timeout that diverts to an error state.
module gumnut_ctrl_seq
  import gumnut_pkg::*;
#(
  parameter int INT_CHANNELS = 4,
  parameter int TIMEOUT      = 15
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    inst_ack_i,
  input  logic                    data_ack_i,
  input  logic                    port_ack_i,
  input  logic                    dec_mem_i,
  input  logic                    dec_flow_i,
  input  logic                    dec_wait_i,
  input  logic [1:0]              mem_fn_i,
  input  logic                    int_en_i,
  input  logic [INT_CHANNELS-1:0] int_req_i,
  output logic                    inst_cyc_o,
  output logic                    inst_stb_o,
  output logic                    data_cyc_o,
  output logic                    data_stb_o,
  output logic                    data_we_o,
  output logic                    port_cyc_o,
  output logic                    port_stb_o,
  output logic                    port_we_o,
  output logic                    ir_load_o,
  output logic                    wb_en_o,
  output logic [INT_CHANNELS-1:0] int_ack_o,
  output logic [2:0]              int_vec_o,
  output logic                    bus_err_o,
  output logic [2:0]              state_o
);

  localparam int CNT_W = (TIMEOUT > 0) ? gumnut_clog2(TIMEOUT + 1) : 1;

  logic [2:0]              state_reg;
  logic [2:0]              state_next;
  logic                    irq;
  logic                    mem_active;
  logic                    is_data;
  logic                    is_write;
  logic                    is_read;
  logic                    mem_ack;
  logic                    timeout_hit;
  logic                    int_load;
  logic [INT_CHANNELS-1:0] grant;

  assign irq        = int_en_i && (|int_req_i);
  assign is_data    = (mem_fn_i == MEM_FN_LDM) || (mem_fn_i == MEM_FN_STM);
  assign is_write   = (mem_fn_i == MEM_FN_STM) || (mem_fn_i == MEM_FN_OUT);
  assign is_read    = !is_write;
  assign mem_ack    = is_data ? data_ack_i : port_ack_i;
  assign mem_active = (state_reg == MEM) || ((state_reg == EXECUTE) && dec_mem_i);

  assign inst_cyc_o = (state_reg == FETCH);
  assign inst_stb_o = inst_cyc_o;
  assign data_cyc_o = mem_active && is_data;
  assign data_stb_o = data_cyc_o;
  assign data_we_o  = data_cyc_o && is_write;
  assign port_cyc_o = mem_active && !is_data;
  assign port_stb_o = port_cyc_o;
  assign port_we_o  = port_cyc_o && is_write;
  assign ir_load_o  = (state_reg == FETCH) && inst_ack_i;
  assign wb_en_o    = (state_reg == WB);
  assign bus_err_o  = (state_reg == ERR);
  assign int_ack_o  = (state_reg == INT) ? grant : '0;
  assign state_o    = state_reg;

  // Wait counter only exists when a finite timeout is configured.
  generate
    if (TIMEOUT > 0) begin : g_timeout
      logic [CNT_W-1:0] cnt_reg;
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          cnt_reg <= '0;
        end else if (state_next != state_reg) begin
          cnt_reg <= '0;
        end else if ((state_reg == FETCH) || (state_reg == MEM)) begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end
      assign timeout_hit = (cnt_reg == CNT_W'(TIMEOUT - 1));
    end else begin : g_no_timeout
      assign timeout_hit = 1'b0;
    end
  endgenerate

  always_comb begin
    state_next = FETCH;
    case (state_reg)
      FETCH: begin
        if (inst_ack_i)       state_next = DECODE;
        else if (timeout_hit) state_next = ERR;
        else                  state_next = FETCH;
      end
      DECODE: begin
        if (dec_flow_i) begin
          if (dec_wait_i && !irq) state_next = DECODE;
          else if (irq)           state_next = INT;
          else                    state_next = FETCH;
        end else begin
          state_next = EXECUTE;
        end
      end
      EXECUTE, MEM: begin
        if ((state_reg == EXECUTE) && !dec_mem_i) state_next = WB;
        else if (mem_ack)                         state_next = is_read ? WB : (irq ? INT : FETCH);
        else if (state_reg == EXECUTE)            state_next = MEM;
        else if (timeout_hit)                     state_next = ERR;
        else                                      state_next = MEM;
      end
      WB, ERR: state_next = irq ? INT : FETCH;
      default: state_next = FETCH;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_reg <= FETCH;
    else       state_reg <= state_next;
  end

  assign int_load = (state_next == INT) && (state_reg != INT);

  gumnut_int_arb #(
    .CHANNELS (INT_CHANNELS)
  ) u_int_arb (
    .clk   (clk_i),
    .srst  (rst_i),
    .load  (int_load),
    .en    (int_en_i),
    .req   (int_req_i),
    .grant (grant),
    .index (int_vec_o)
  );

endmodule

// File: tb/tb_gumnut_ctrl_seq.sv
// Self-checking bench for gumnut_ctrl_seq (4 interrupt channels, timeout 4).
// Directed scenarios plus a randomized run against a cycle-level reference model.
module tb_gumnut_ctrl_seq;

  localparam int TO = 4;

  logic       clk = 1'b0;
  logic       rst, inst_ack, data_ack, port_ack, dec_mem, dec_flow, dec_wait, int_en;
  logic [1:0] mem_fn;
  logic [3:0] int_req;
  logic       inst_cyc, inst_stb, data_cyc, data_stb, data_we;
  logic       port_cyc, port_stb, port_we, ir_load, wb_en, bus_err;
  logic [3:0] int_ack;
  logic [2:0] int_vec, state;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  int         m_state, m_wait, m_vec, m_gnt;
  logic [20:0] exp_obs;
  logic [20:0] obs;

  gumnut_ctrl_seq #(.INT_CHANNELS(4), .TIMEOUT(TO)) dut (
    .clk_i(clk), .rst_i(rst), .inst_ack_i(inst_ack), .data_ack_i(data_ack),
    .port_ack_i(port_ack), .dec_mem_i(dec_mem), .dec_flow_i(dec_flow),
    .dec_wait_i(dec_wait), .mem_fn_i(mem_fn), .int_en_i(int_en), .int_req_i(int_req),
    .inst_cyc_o(inst_cyc), .inst_stb_o(inst_stb), .data_cyc_o(data_cyc),
    .data_stb_o(data_stb), .data_we_o(data_we), .port_cyc_o(port_cyc),
    .port_stb_o(port_stb), .port_we_o(port_we), .ir_load_o(ir_load), .wb_en_o(wb_en),
    .int_ack_o(int_ack), .int_vec_o(int_vec), .bus_err_o(bus_err), .state_o(state)
  );

  always #5 clk = ~clk;

  assign obs = {state, inst_cyc, inst_stb, data_cyc, data_stb, data_we,
                port_cyc, port_stb, port_we, ir_load, wb_en, int_ack, int_vec, bus_err};

  function automatic int lowest_req(input logic [3:0] r);
    for (int i = 0; i < 4; i++) if (r[i]) return i;
    return 0;
  endfunction

  // Expected outputs for the current cycle from model state and live inputs.
  task automatic model_eval();
    bit memop, dside, wr;
    logic [3:0] ack;
    memop = (m_state == 3) || (m_state == 2 && dec_mem);
    dside = (mem_fn < 2);
    wr    = mem_fn[0];
    ack   = (m_state == 5) ? 4'(1 << m_gnt) : 4'b0;
    exp_obs = {3'(m_state), m_state == 0, m_state == 0,
               memop && dside, memop && dside, memop && dside && wr,
               memop && !dside, memop && !dside, memop && !dside && wr,
               (m_state == 0) && inst_ack, m_state == 4, ack, 3'(m_vec), m_state == 6};
  endtask

  // Advance the model across one rising edge using the inputs held at that edge.
  task automatic model_advance();
    int nxt;
    bit irq, ackm, timed, is_rd;
    if (rst) begin
      m_state = 0; m_wait = 0; m_vec = 0;
      return;
    end
    irq   = int_en && (int_req != 0);
    ackm  = (mem_fn < 2) ? data_ack : port_ack;
    timed = (m_wait == TO - 1);
    is_rd = (mem_fn == 2'b00) || (mem_fn == 2'b10);
    case (m_state)
      0: nxt = inst_ack ? 1 : (timed ? 6 : 0);
      1: nxt = dec_flow ? ((dec_wait && !irq) ? 1 : (irq ? 5 : 0)) : 2;
      2: nxt = !dec_mem ? 4 : (ackm ? (is_rd ? 4 : (irq ? 5 : 0)) : 3);
      3: nxt = ackm ? (is_rd ? 4 : (irq ? 5 : 0)) : (timed ? 6 : 3);
      4, 6: nxt = irq ? 5 : 0;
      default: nxt = 0;
    endcase
    if (nxt == 5) begin
      m_gnt = lowest_req(int_req);
      m_vec = m_gnt;
    end
    if (nxt != m_state) m_wait = 0;
    else if (m_state == 0 || m_state == 3) m_wait++;
    m_state = nxt;
  endtask

  task automatic settle();
    #1;
    model_eval();
  endtask

  task automatic clock_edge();
    @(posedge clk);
    model_advance();
    #1;
  endtask

  task automatic clear_inputs();
    inst_ack = 0; data_ack = 0; port_ack = 0; dec_mem = 0; dec_flow = 0;
    dec_wait = 0; mem_fn = 2'b00; int_en = 0; int_req = 4'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1;
    clock_edge();
    clock_edge();
    rst = 0;
  endtask

  task automatic test_reset();
    do_reset();
    settle();
    vectors++;
    if (obs !== exp_obs) begin
      miscompares++;
      $display("FAIL reset_model: got %h want %h", obs, exp_obs);
    end
    vectors++;
    if ({state, inst_cyc, inst_stb, int_vec, int_ack, wb_en, bus_err} !== {3'd0, 1'b1, 1'b1, 3'd0, 4'd0, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_state: state=%0d inst_cyc=%b vec=%0d ack=%b wb=%b err=%b, want 0,1,0,0000,0,0",
               state, inst_cyc, int_vec, int_ack, wb_en, bus_err);
    end
  endtask

  task automatic test_alu();
    int seq[6] = '{0, 0, 1, 2, 4, 0};
    int wb_count = 0;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      inst_ack = (i == 1);
      settle();
      vectors++;
      if (obs !== exp_obs || state !== 3'(seq[i])) begin
        miscompares++;
        $display("FAIL alu cyc%0d: got %h state %0d want %h state %0d", i, obs, state, exp_obs, seq[i]);
      end
      if (wb_en) wb_count++;
      clock_edge();
    end
    vectors++;
    if (wb_count != 1) begin
      miscompares++;
      $display("FAIL alu_wb_count: got %0d want 1", wb_count);
    end
  endtask

  task automatic test_stm();
    int seq[7] = '{0, 1, 2, 3, 3, 3, 0};
    bit we[7]  = '{0, 0, 1, 1, 1, 1, 0};
    do_reset();
    dec_mem = 1; mem_fn = 2'b01;
    for (int i = 0; i < 7; i++) begin
      inst_ack = (i == 0);
      data_ack = (i == 5);
      settle();
      vectors++;
      if (obs !== exp_obs || state !== 3'(seq[i]) || data_we !== we[i] || wb_en !== 1'b0) begin
        miscompares++;
        $display("FAIL stm cyc%0d: got %h state %0d we %b want %h state %0d we %b",
                 i, obs, state, data_we, exp_obs, seq[i], we[i]);
      end
      clock_edge();
    end
  endtask

  task automatic test_timeout();
    int seq_err[6] = '{0, 0, 0, 0, 6, 0};
    int seq_ok[5]  = '{0, 0, 0, 0, 1};
    int errs = 0;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      settle();
      vectors++;
      if (obs !== exp_obs || state !== 3'(seq_err[i]) || bus_err !== (i == 4)) begin
        miscompares++;
        $display("FAIL timeout cyc%0d: got %h state %0d err %b want %h state %0d",
                 i, obs, state, bus_err, exp_obs, seq_err[i]);
      end
      clock_edge();
    end
    do_reset();
    for (int i = 0; i < 5; i++) begin
      inst_ack = (i == 3);
      settle();
      vectors++;
      if (obs !== exp_obs || state !== 3'(seq_ok[i])) begin
        miscompares++;
        $display("FAIL timeout_ack cyc%0d: got %h state %0d want %h state %0d",
                 i, obs, state, exp_obs, seq_ok[i]);
      end
      if (bus_err) errs++;
      clock_edge();
    end
    vectors++;
    if (errs != 0) begin
      miscompares++;
      $display("FAIL timeout_ack_err: got %0d error pulses want 0", errs);
    end
  endtask

  task automatic test_int();
    int seq[6] = '{0, 1, 2, 4, 5, 0};
    do_reset();
    int_en = 1;
    for (int i = 0; i < 6; i++) begin
      inst_ack = (i == 0);
      int_req  = (i == 3) ? 4'b1010 : 4'b0000;
      settle();
      vectors++;
      if (obs !== exp_obs || state !== 3'(seq[i])) begin
        miscompares++;
        $display("FAIL int cyc%0d: got %h state %0d want %h state %0d", i, obs, state, exp_obs, seq[i]);
      end
      if (i == 4) begin
        vectors++;
        if (int_ack !== 4'b0010 || int_vec !== 3'd1) begin
          miscompares++;
          $display("FAIL int_ack: got ack %b vec %0d want 0010 vec 1", int_ack, int_vec);
        end
      end
      clock_edge();
    end
  endtask

  task automatic test_wait();
    do_reset();
    int_en = 1; dec_flow = 1; dec_wait = 1;
    for (int i = 0; i < 14; i++) begin
      inst_ack = (i == 0);
      int_req  = (i == 11) ? 4'b1000 : 4'b0000;
      settle();
      vectors++;
      if (obs !== exp_obs) begin
        miscompares++;
        $display("FAIL wait cyc%0d: got %h want %h", i, obs, exp_obs);
      end
      if (i >= 1 && i <= 11 && state !== 3'd1) begin
        miscompares++;
        $display("FAIL wait_hold cyc%0d: got state %0d want 1", i, state);
      end
      if (i == 12 && (state !== 3'd5 || int_vec !== 3'd3 || int_ack !== 4'b1000)) begin
        miscompares++;
        $display("FAIL wait_int: got state %0d vec %0d ack %b want 5 3 1000", state, int_vec, int_ack);
      end
      clock_edge();
    end
  endtask

  task automatic test_reset_mid();
    int seq[6] = '{0, 1, 2, 3, 0, 0};
    do_reset();
    dec_mem = 1; mem_fn = 2'b00;
    for (int i = 0; i < 6; i++) begin
      inst_ack = (i == 0);
      rst      = (i == 3);
      settle();
      vectors++;
      if (obs !== exp_obs || state !== 3'(seq[i]) || wb_en !== 1'b0 || data_cyc !== (i == 2 || i == 3)) begin
        miscompares++;
        $display("FAIL reset_mid cyc%0d: got %h state %0d dcyc %b wb %b want %h state %0d",
                 i, obs, state, data_cyc, wb_en, exp_obs, seq[i]);
      end
      clock_edge();
    end
    rst = 0;
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      rst      = ($urandom_range(0, 99) == 0);
      inst_ack = ($urandom_range(0, 2) == 0);
      data_ack = ($urandom_range(0, 2) == 0);
      port_ack = ($urandom_range(0, 2) == 0);
      if (m_state == 0) begin
        dec_mem  = 1'($urandom);
        dec_flow = 1'($urandom);
        dec_wait = 1'($urandom);
        mem_fn   = 2'($urandom);
      end
      if ($urandom_range(0, 15) == 0) int_en = 1'($urandom);
      int_req = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0000;
      settle();
      vectors++;
      if (obs !== exp_obs) begin
        miscompares++;
        $display("FAIL random cyc%0d: got %h want %h (model state %0d)", c, obs, exp_obs, m_state);
      end
      clock_edge();
    end
    rst = 0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    m_state = 0; m_wait = 0; m_vec = 0; m_gnt = 0;
    rst = 1;
    clear_inputs();
    test_reset();
    test_alu();
    test_stm();
    test_timeout();
    test_int();
    test_wait();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
